// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Source end of the VGA timing interface. Produces the pixel column/row
// counters consumed by the game logic, the horizontal and vertical sync
// pulses, and the active-area decode. The game's combinational RGB for the
// current counter position is registered, blanked outside the visible area
// and delayed so that sync, blanking and colour leave the block aligned.
//
// Ports
//   i_Clk          in   1   pixel clock
//   i_Rst          in   1   synchronous reset, active high
//   i_En           in   1   count enable; when low, every register holds
//   i_Red_Video    in   4   colour for the current o_Col_Count/o_Row_Count
//   i_Grn_Video    in   4   colour for the current o_Col_Count/o_Row_Count
//   i_Blu_Video    in   4   colour for the current o_Col_Count/o_Row_Count
//   o_Col_Count    out 10   current column, 0..c_TOTAL_COLS-1
//   o_Row_Count    out 10   current row, 0..c_TOTAL_ROWS-1
//   o_Active       out  1   counters are inside the visible area
//   o_Frame_Start  out  1   one-clock pulse when the counters sit at (0,0)
//   o_Frame_Count  out  8   frame counter, wraps 255 -> 0
//   o_HSync        out  1   horizontal sync to pin, active low
//   o_VSync        out  1   vertical sync to pin, active low
//   o_Red_Video    out  4   blanked, aligned colour to pin
//   o_Grn_Video    out  4   blanked, aligned colour to pin
//   o_Blu_Video    out  4   blanked, aligned colour to pin
//
// Pin outputs (sync and colour) lag the counters by 1 + c_VIDEO_DELAY clocks.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int c_TOTAL_COLS  = 800,
    parameter int c_TOTAL_ROWS  = 525,
    parameter int c_ACTIVE_COLS = 640,
    parameter int c_ACTIVE_ROWS = 480,
    parameter int c_H_FRONT     = 16,
    parameter int c_H_SYNC      = 96,
    parameter int c_V_FRONT     = 10,
    parameter int c_V_SYNC      = 2,
    parameter int c_VIDEO_DELAY = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_En,
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Frame_Start,
    output logic [7:0] o_Frame_Count,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [3:0] o_Red_Video,
    output logic [3:0] o_Grn_Video,
    output logic [3:0] o_Blu_Video
);

    // -------------------------------------------------------------------------
    // Elaboration-time sanity checks on the timing parameters. Each phase must
    // be at least one clock/line long so the phase FSMs visit every state, and
    // the back porch must be non-empty.
    // -------------------------------------------------------------------------
    if (c_TOTAL_COLS > 1024 || c_TOTAL_ROWS > 1024) begin : g_err_size
        $error("vga_sync_gen: frame dimensions exceed the 10-bit counters");
    end
    if (c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC >= c_TOTAL_COLS) begin : g_err_h
        $error("vga_sync_gen: horizontal active+front+sync must be < total");
    end
    if (c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC >= c_TOTAL_ROWS) begin : g_err_v
        $error("vga_sync_gen: vertical active+front+sync must be < total");
    end
    if (c_ACTIVE_COLS < 1 || c_H_FRONT < 1 || c_H_SYNC < 1) begin : g_err_hmin
        $error("vga_sync_gen: horizontal phases must be at least one clock");
    end
    if (c_ACTIVE_ROWS < 1 || c_V_FRONT < 1 || c_V_SYNC < 1) begin : g_err_vmin
        $error("vga_sync_gen: vertical phases must be at least one line");
    end
    if (c_VIDEO_DELAY < 0 || c_VIDEO_DELAY > 3) begin : g_err_delay
        $error("vga_sync_gen: c_VIDEO_DELAY must be within 0..3");
    end

    // Phase boundaries as 10-bit constants: the first column/row of each phase.
    localparam logic [9:0] c_H_FRONT_START = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] c_H_SYNC_START  = 10'(c_ACTIVE_COLS + c_H_FRONT);
    localparam logic [9:0] c_H_BACK_START  = 10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC);
    localparam logic [9:0] c_H_LAST        = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] c_V_FRONT_START = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] c_V_SYNC_START  = 10'(c_ACTIVE_ROWS + c_V_FRONT);
    localparam logic [9:0] c_V_BACK_START  = 10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC);
    localparam logic [9:0] c_V_LAST        = 10'(c_TOTAL_ROWS - 1);

    // Phase of a line (or of a frame, for the vertical FSM).
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } phase_t;

    logic [9:0] col_r;
    logic [9:0] row_r;
    logic [7:0] frame_cnt_r;
    phase_t     h_state_r;
    phase_t     v_state_r;

    logic [9:0] col_next_s;
    logic [9:0] row_next_s;
    logic       line_end_s;
    logic       frame_end_s;
    logic       active_s;
    logic       hsync_raw_s;
    logic       vsync_raw_s;
    logic       frame_start_s;

    // Stage 0 is the first register after the counters; stages
    // 1..c_VIDEO_DELAY are the extra alignment delay.
    logic       hsync_pipe_r [0:c_VIDEO_DELAY];
    logic       vsync_pipe_r [0:c_VIDEO_DELAY];
    logic [3:0] red_pipe_r   [0:c_VIDEO_DELAY];
    logic [3:0] grn_pipe_r   [0:c_VIDEO_DELAY];
    logic [3:0] blu_pipe_r   [0:c_VIDEO_DELAY];

    // Next counter values and line/frame wrap decode.
    always_comb begin
        line_end_s  = (col_r == c_H_LAST);
        frame_end_s = line_end_s && (row_r == c_V_LAST);
        if (line_end_s) begin
            col_next_s = 10'd0;
        end else begin
            col_next_s = col_r + 10'd1;
        end
        if (frame_end_s) begin
            row_next_s = 10'd0;
        end else if (line_end_s) begin
            row_next_s = row_r + 10'd1;
        end else begin
            row_next_s = row_r;
        end
    end

    // Column/row counters and frame counter.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            col_r       <= 10'd0;
            row_r       <= 10'd0;
            frame_cnt_r <= 8'd0;
        end else if (i_En) begin
            col_r <= col_next_s;
            row_r <= row_next_s;
            if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
        end
    end

    // Horizontal phase FSM. Transitions look at the next column so the state
    // register always describes the column currently held in col_r.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            h_state_r <= ST_ACTIVE;
        end else if (i_En) begin
            case (h_state_r)
                ST_ACTIVE: if (col_next_s == c_H_FRONT_START) h_state_r <= ST_FRONT;
                ST_FRONT:  if (col_next_s == c_H_SYNC_START)  h_state_r <= ST_SYNC;
                ST_SYNC:   if (col_next_s == c_H_BACK_START)  h_state_r <= ST_BACK;
                ST_BACK:   if (col_next_s == 10'd0)           h_state_r <= ST_ACTIVE;
                default:   h_state_r <= ST_ACTIVE;
            endcase
        end
    end

    // Vertical phase FSM, stepped only on the clock that wraps a line.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            v_state_r <= ST_ACTIVE;
        end else if (i_En && line_end_s) begin
            case (v_state_r)
                ST_ACTIVE: if (row_next_s == c_V_FRONT_START) v_state_r <= ST_FRONT;
                ST_FRONT:  if (row_next_s == c_V_SYNC_START)  v_state_r <= ST_SYNC;
                ST_SYNC:   if (row_next_s == c_V_BACK_START)  v_state_r <= ST_BACK;
                ST_BACK:   if (row_next_s == 10'd0)           v_state_r <= ST_ACTIVE;
                default:   v_state_r <= ST_ACTIVE;
            endcase
        end
    end

    // Decodes aligned with the counter registers. The frame-start pulse is
    // suppressed while reset is held, so the first pulse appears on the clock
    // reset is released, with the counters parked at (0,0).
    always_comb begin
        active_s      = (col_r < c_H_FRONT_START) && (row_r < c_V_FRONT_START);
        hsync_raw_s   = (h_state_r != ST_SYNC);
        vsync_raw_s   = (v_state_r != ST_SYNC);
        frame_start_s = (col_r == 10'd0) && (row_r == 10'd0) && !i_Rst;
    end

    // Output pipeline. Blanking is folded into the stage-0 colour register, so
    // the zeroed colour itself carries the blank through the delay stages and
    // stays aligned with the delayed sync.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i <= c_VIDEO_DELAY; i++) begin
                hsync_pipe_r[i] <= 1'b1;
                vsync_pipe_r[i] <= 1'b1;
                red_pipe_r[i]   <= 4'h0;
                grn_pipe_r[i]   <= 4'h0;
                blu_pipe_r[i]   <= 4'h0;
            end
        end else if (i_En) begin
            hsync_pipe_r[0] <= hsync_raw_s;
            vsync_pipe_r[0] <= vsync_raw_s;
            red_pipe_r[0]   <= active_s ? i_Red_Video : 4'h0;
            grn_pipe_r[0]   <= active_s ? i_Grn_Video : 4'h0;
            blu_pipe_r[0]   <= active_s ? i_Blu_Video : 4'h0;
            for (int i = 1; i <= c_VIDEO_DELAY; i++) begin
                hsync_pipe_r[i] <= hsync_pipe_r[i-1];
                vsync_pipe_r[i] <= vsync_pipe_r[i-1];
                red_pipe_r[i]   <= red_pipe_r[i-1];
                grn_pipe_r[i]   <= grn_pipe_r[i-1];
                blu_pipe_r[i]   <= blu_pipe_r[i-1];
            end
        end
    end

    assign o_Col_Count   = col_r;
    assign o_Row_Count   = row_r;
    assign o_Frame_Count = frame_cnt_r;
    assign o_Active      = active_s;
    assign o_Frame_Start = frame_start_s;
    assign o_HSync       = hsync_pipe_r[c_VIDEO_DELAY];
    assign o_VSync       = vsync_pipe_r[c_VIDEO_DELAY];
    assign o_Red_Video   = red_pipe_r[c_VIDEO_DELAY];
    assign o_Grn_Video   = grn_pipe_r[c_VIDEO_DELAY];
    assign o_Blu_Video   = blu_pipe_r[c_VIDEO_DELAY];

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Two instances share the clock and inputs: dut_d uses the default 640x480
// timing for line-level checks; dut_s uses a tiny 20x12 frame (active 10x6,
// H front 2 / sync 3, V front 2 / sync 2, video delay 2) so whole frames and
// the 256-frame counter wrap fit in a short run. Expected values are
// hand-computed from the timing parameters.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [3:0] red_in, grn_in, blu_in;

    logic [9:0] s_col, s_row, d_col, d_row;
    logic       s_active, s_fs, s_hs, s_vs, d_active, d_fs, d_hs, d_vs;
    logic [7:0] s_fc, d_fc;
    logic [3:0] s_red, s_grn, s_blu, d_red, d_grn, d_blu;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    vga_sync_gen #(
        .c_TOTAL_COLS(20), .c_TOTAL_ROWS(12), .c_ACTIVE_COLS(10), .c_ACTIVE_ROWS(6),
        .c_H_FRONT(2), .c_H_SYNC(3), .c_V_FRONT(2), .c_V_SYNC(2), .c_VIDEO_DELAY(2)
    ) dut_s (
        .i_Clk(clk), .i_Rst(rst), .i_En(en),
        .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
        .o_Col_Count(s_col), .o_Row_Count(s_row), .o_Active(s_active),
        .o_Frame_Start(s_fs), .o_Frame_Count(s_fc), .o_HSync(s_hs), .o_VSync(s_vs),
        .o_Red_Video(s_red), .o_Grn_Video(s_grn), .o_Blu_Video(s_blu)
    );

    vga_sync_gen dut_d (
        .i_Clk(clk), .i_Rst(rst), .i_En(en),
        .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
        .o_Col_Count(d_col), .o_Row_Count(d_row), .o_Active(d_active),
        .o_Frame_Start(d_fs), .o_Frame_Count(d_fc), .o_HSync(d_hs), .o_VSync(d_vs),
        .o_Red_Video(d_red), .o_Grn_Video(d_grn), .o_Blu_Video(d_blu)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Phase a counter value falls in: 0 active, 1 front, 2 sync, 3 back.
    function automatic int phase_of(input int pos, input int act, input int fr, input int sy);
        if (pos < act) return 0;
        else if (pos < act + fr) return 1;
        else if (pos < act + fr + sy) return 2;
        else return 3;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Phase FSMs must match the counter decode on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_hstate", 32'(int'(dut_s.h_state_r)), 32'(phase_of(int'(s_col), 10, 2, 3)));
            check("s_vstate", 32'(int'(dut_s.v_state_r)), 32'(phase_of(int'(s_row), 6, 2, 2)));
            check("d_hstate", 32'(int'(dut_d.h_state_r)), 32'(phase_of(int'(d_col), 640, 16, 96)));
            check("d_vstate", 32'(int'(dut_d.v_state_r)), 32'(phase_of(int'(d_row), 480, 10, 2)));
        end
    end

    initial begin
        int   fall1, fall2, lowlen, hfall, hlen, vfall, vlen, fs_cnt, f_cnt, z_cnt, n, last;
        logic prev_h, prev_v;

        rst = 1'b1; en = 1'b1; red_in = 4'hF; grn_in = 4'hA; blu_in = 4'h5;
        repeat (3) tick();

        // Reset state
        check("rst_col",    32'(s_col),    32'd0);
        check("rst_row",    32'(s_row),    32'd0);
        check("rst_active", 32'(s_active), 32'd1);
        check("rst_fs",     32'(s_fs),     32'd0);
        check("rst_fc",     32'(s_fc),     32'd0);
        check("rst_hs",     32'(s_hs),     32'd1);
        check("rst_vs",     32'(s_vs),     32'd1);
        check("rst_red",    32'(s_red),    32'd0);
        check("rst_grn",    32'(s_grn),    32'd0);
        check("rst_blu",    32'(s_blu),    32'd0);
        check("rst_d_hs",   32'(d_hs),     32'd1);
        check("rst_d_vs",   32'(d_vs),     32'd1);
        rst = 1'b0;
        #1;
        chk_en = 1'b1;
        check("first_fs", 32'(s_fs), 32'd1);

        // Default timing: one line and a bit, HSync position/width/period
        prev_h = 1'b1; fall1 = -1; fall2 = -1; lowlen = 0;
        for (int k = 0; k < 1600; k++) begin
            if (prev_h && !d_hs) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!d_hs && fall2 < 0) lowlen++;
            prev_h = d_hs;
            if (k == 1)   check("d_red_k1",   32'(d_red), 32'd0);
            if (k == 2)   check("d_red_k2",   32'(d_red), 32'd15);
            if (k == 641) check("d_red_k641", 32'(d_red), 32'd15);
            if (k == 642) check("d_red_k642", 32'(d_red), 32'd0);
            if (k == 700) check("d_col_k700", 32'(d_col), 32'd700);
            tick();
        end
        check("d_hs_start",  32'(fall1),         32'd658);
        check("d_hs_width",  32'(lowlen),        32'd96);
        check("d_hs_period", 32'(fall2 - fall1), 32'd800);

        // Small timing: two full frames
        do_reset();
        prev_h = 1'b1; prev_v = 1'b1; hfall = -1; hlen = 0; vfall = -1; vlen = 0;
        fs_cnt = 0; f_cnt = 0; z_cnt = 0;
        for (int k = 0; k < 490; k++) begin
            if (prev_h && !s_hs && hfall < 0) hfall = k;
            if (hfall >= 0 && k < hfall + 20 && !s_hs) hlen++;
            if (prev_v && !s_vs && vfall < 0) vfall = k;
            if (vfall >= 0 && k < vfall + 240 && !s_vs) vlen++;
            prev_h = s_hs; prev_v = s_vs;
            if (s_fs) fs_cnt++;
            if (k >= 3 && k < 243) begin
                if (s_red == 4'hF) f_cnt++;
                else if (s_red == 4'h0) z_cnt++;
            end
            if (k == 0 || k == 240 || k == 480) check("fs_pulse", 32'(s_fs), 32'd1);
            if (k == 1)   check("fs_k1",       32'(s_fs),     32'd0);
            if (k == 239) check("fc_k239",     32'(s_fc),     32'd0);
            if (k == 240) check("fc_k240",     32'(s_fc),     32'd1);
            if (k == 480) check("fc_k480",     32'(s_fc),     32'd2);
            if (k == 239) check("col_k239",    32'(s_col),    32'd19);
            if (k == 239) check("row_k239",    32'(s_row),    32'd11);
            if (k == 9)   check("active_k9",   32'(s_active), 32'd1);
            if (k == 10)  check("active_k10",  32'(s_active), 32'd0);
            if (k == 100) check("active_k100", 32'(s_active), 32'd1);
            if (k == 119) check("active_k119", 32'(s_active), 32'd0);
            if (k == 120) check("active_k120", 32'(s_active), 32'd0);
            if (k == 3)   check("grn_k3",      32'(s_grn),    32'd10);
            if (k == 3)   check("blu_k3",      32'(s_blu),    32'd5);
            if (k == 12)  check("red_k12",     32'(s_red),    32'd15);
            if (k == 13)  check("grn_k13",     32'(s_grn),    32'd0);
            if (k == 103) check("red_k103",    32'(s_red),    32'd15);
            if (k == 123) check("red_k123",    32'(s_red),    32'd0);
            tick();
        end
        check("hs_start",  32'(hfall),  32'd15);
        check("hs_width",  32'(hlen),   32'd3);
        check("vs_start",  32'(vfall),  32'd163);
        check("vs_width",  32'(vlen),   32'd40);
        check("fs_count",  32'(fs_cnt), 32'd3);
        check("lit_count", 32'(f_cnt),  32'd60);
        check("blk_count", 32'(z_cnt),  32'd180);

        // Enable hold at (15,2) for 50 clocks; HSync output is low there
        do_reset();
        repeat (55) tick();
        check("hold_pre_col", 32'(s_col), 32'd15);
        check("hold_pre_row", 32'(s_row), 32'd2);
        check("hold_pre_hs",  32'(s_hs),  32'd0);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("hold_col",    32'(s_col),    32'd15);
            check("hold_row",    32'(s_row),    32'd2);
            check("hold_hs",     32'(s_hs),     32'd0);
            check("hold_vs",     32'(s_vs),     32'd1);
            check("hold_red",    32'(s_red),    32'd0);
            check("hold_active", 32'(s_active), 32'd0);
            check("hold_fs",     32'(s_fs),     32'd0);
            check("hold_fc",     32'(s_fc),     32'd0);
        end
        en = 1'b1;
        tick();
        check("resume_col1", 32'(s_col), 32'd16);
        check("resume_hs1",  32'(s_hs),  32'd0);
        tick();
        check("resume_col2", 32'(s_col), 32'd17);
        check("resume_hs2",  32'(s_hs),  32'd0);
        tick();
        check("resume_col3", 32'(s_col), 32'd18);
        check("resume_hs3",  32'(s_hs),  32'd1);

        // Reset in the middle of frame 1 at (5,3)
        do_reset();
        repeat (305) tick();
        check("mid_col",    32'(s_col),    32'd5);
        check("mid_row",    32'(s_row),    32'd3);
        check("mid_fc",     32'(s_fc),     32'd1);
        check("mid_red",    32'(s_red),    32'd15);
        check("mid_active", 32'(s_active), 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_col", 32'(s_col), 32'd0);
        check("mrst_row", 32'(s_row), 32'd0);
        check("mrst_hs",  32'(s_hs),  32'd1);
        check("mrst_vs",  32'(s_vs),  32'd1);
        check("mrst_red", 32'(s_red), 32'd0);
        check("mrst_fc",  32'(s_fc),  32'd0);
        check("mrst_fs",  32'(s_fs),  32'd0);
        rst = 1'b0;
        #1;
        check("mrst_fs_release", 32'(s_fs), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_fs && n < 400);
        check("mrst_next_fs", 32'(n), 32'd240);

        // 256 frames: frame counter wrap and one pulse per frame
        do_reset();
        fs_cnt = 0; last = 0;
        for (int k = 0; k <= 61440; k++) begin
            if (s_fs) begin
                if (k < 61440) fs_cnt++;
                if (k > 0) check("fs_spacing", 32'(k - last), 32'd240);
                last = k;
            end
            if (k == 61439) check("fc_before_wrap", 32'(s_fc), 32'd255);
            if (k == 61440) begin
                check("fc_after_wrap", 32'(s_fc), 32'd0);
                check("fs_at_wrap",    32'(s_fs), 32'd1);
            end
            tick();
        end
        check("fs_256", 32'(fs_cnt), 32'd256);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
